// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read handshake between the fetch stage (master) and I-memory (slave).
interface if_fetch_stage_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [WORD_SIZE-1:0] i_data;
    logic                 i_ready;

    modport master (
        output i_readM,
        output i_address,
        input  i_data,
        input  i_ready
    );

    modport slave (
        input  i_readM,
        input  i_address,
        output i_data,
        output i_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: REQ/HOLD/DRAIN fetch FSM with optional BTB branch prediction.
// Optional feature macro: BTB_PREDICT_EN (default build predicts pc+1 and ignores bp_update*).
module if_fetch_stage #(
    parameter int WORD_SIZE    = 16,
    parameter int BTB_IDX_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 bp_update,
    input  logic [WORD_SIZE-1:0] bp_update_pc,
    input  logic [WORD_SIZE-1:0] bp_update_target,
    input  logic                 bp_update_taken,
    if_fetch_stage_if.master     imem,
    output logic [WORD_SIZE-1:0] pc_IF,
    output logic [WORD_SIZE-1:0] branch_predicted_pc_IF,
    output logic [WORD_SIZE-1:0] instruction_IF,
    output logic                 valid_IF
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0] hold_instr_q, hold_instr_d;
    logic [WORD_SIZE-1:0] hold_pred_q, hold_pred_d;
    logic [WORD_SIZE-1:0] pred_s;
    logic [WORD_SIZE-1:0] instr_s;
    logic [WORD_SIZE-1:0] pred_out_s;
    logic                 valid_s;

`ifdef BTB_PREDICT_EN
    localparam int TAG_W     = WORD_SIZE - BTB_IDX_BITS;
    localparam int BTB_DEPTH = 2 ** BTB_IDX_BITS;

    logic                    btb_valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0]        btb_tag_q    [BTB_DEPTH];
    logic [WORD_SIZE-1:0]    btb_target_q [BTB_DEPTH];
    logic [1:0]              btb_cnt_q    [BTB_DEPTH];
    logic [BTB_IDX_BITS-1:0] lk_idx_s;
    logic [BTB_IDX_BITS-1:0] up_idx_s;
    logic                    lk_hit_s;
    logic                    up_hit_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    assign lk_idx_s = req_addr_q[BTB_IDX_BITS-1:0];
    assign lk_hit_s = btb_valid_q[lk_idx_s] &&
                      (btb_tag_q[lk_idx_s] == req_addr_q[WORD_SIZE-1:BTB_IDX_BITS]);
    assign pred_s   = (lk_hit_s && (btb_cnt_q[lk_idx_s] >= 2'd2)) ?
                      btb_target_q[lk_idx_s] : req_addr_q + WORD_SIZE'(1);

    assign up_idx_s = bp_update_pc[BTB_IDX_BITS-1:0];
    assign up_hit_s = btb_valid_q[up_idx_s] &&
                      (btb_tag_q[up_idx_s] == bp_update_pc[WORD_SIZE-1:BTB_IDX_BITS]);

    // BTB training from resolved branches; reset clears valid bits and sets counters weakly not-taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_cnt_q[i]    <= 2'd1;
            end
        end else if (bp_update) begin
            if (up_hit_s) begin
                if (bp_update_taken) begin
                    btb_cnt_q[up_idx_s]    <= sat_inc(btb_cnt_q[up_idx_s]);
                    btb_target_q[up_idx_s] <= bp_update_target;
                end else begin
                    btb_cnt_q[up_idx_s] <= sat_dec(btb_cnt_q[up_idx_s]);
                end
            end else if (bp_update_taken) begin
                btb_valid_q[up_idx_s]  <= 1'b1;
                btb_tag_q[up_idx_s]    <= bp_update_pc[WORD_SIZE-1:BTB_IDX_BITS];
                btb_target_q[up_idx_s] <= bp_update_target;
                btb_cnt_q[up_idx_s]    <= 2'd2;
            end
        end
    end
`else
    logic unused_s;

    assign pred_s   = req_addr_q + WORD_SIZE'(1);
    assign unused_s = ^{bp_update, bp_update_pc, bp_update_target, bp_update_taken,
                        (BTB_IDX_BITS > 0)};
`endif

    // Fetch state, PC and captured-word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= '0;
            req_addr_q   <= '0;
            hold_instr_q <= '0;
            hold_pred_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pred_q  <= hold_pred_d;
        end
    end

    // Next-state and IF/ID output selection; redirect overrides any delivery in the same cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pred_d  = hold_pred_q;
        valid_s      = 1'b0;
        instr_s      = hold_instr_q;
        pred_out_s   = hold_pred_q;
        case (state_q)
            ST_REQ: begin
                instr_s    = imem.i_data;
                pred_out_s = pred_s;
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem.i_ready) begin
                        req_addr_d = redirect_pc;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem.i_ready) begin
                    valid_s = 1'b1;
                    if (stall) begin
                        hold_instr_d = imem.i_data;
                        hold_pred_d  = pred_s;
                        state_d      = ST_HOLD;
                    end else begin
                        pc_d       = pred_s;
                        req_addr_d = pred_s;
                        state_d    = ST_REQ;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = ST_REQ;
                end else begin
                    valid_s = 1'b1;
                    if (stall) begin
                        state_d = ST_HOLD;
                    end else begin
                        pc_d       = hold_pred_q;
                        req_addr_d = hold_pred_q;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    pc_d = pc_q;
                end
                if (imem.i_ready) begin
                    req_addr_d = redirect ? redirect_pc : pc_q;
                    state_d    = ST_REQ;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    assign imem.i_readM           = (state_q != ST_HOLD);
    assign imem.i_address         = req_addr_q;
    assign pc_IF                  = req_addr_q;
    assign instruction_IF         = instr_s;
    assign branch_predicted_pc_IF = pred_out_s;
    assign valid_IF               = valid_s & ~reset;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: transaction-level model plus directed literal checks.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        bp_update = 1'b0;
    logic [15:0] bp_update_pc = 16'h0000;
    logic [15:0] bp_update_target = 16'h0000;
    logic        bp_update_taken = 1'b0;
    logic [15:0] pc_IF, branch_predicted_pc_IF, instruction_IF;
    logic        valid_IF;

    int checks = 0;
    int errors = 0;

    if_fetch_stage_if #(.WORD_SIZE(16)) ifc ();

    if_fetch_stage #(.WORD_SIZE(16), .BTB_IDX_BITS(8)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .stall                  (stall),
        .redirect               (redirect),
        .redirect_pc            (redirect_pc),
        .bp_update              (bp_update),
        .bp_update_pc           (bp_update_pc),
        .bp_update_target       (bp_update_target),
        .bp_update_taken        (bp_update_taken),
        .imem                   (ifc),
        .pc_IF                  (pc_IF),
        .branch_predicted_pc_IF (branch_predicted_pc_IF),
        .instruction_IF         (instruction_IF),
        .valid_IF               (valid_IF)
    );

    always #5 clk = ~clk;

    // Memory content is the inverted address; an idle bus returns a poison word.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return ~a;
    endfunction
    assign ifc.i_data = ifc.i_readM ? mem_word(ifc.i_address) : 16'hDEAD;

    // ---------------- behavioural model ----------------
    logic [15:0] m_addr = 16'h0000;   // address the fetcher is (or will be) asking for
    logic [15:0] m_next = 16'h0000;   // where fetching continues after a discarded response
    logic [15:0] m_hword = 16'h0000;
    logic [15:0] m_hpred = 16'h0000;
    bit          m_known = 1'b0;
    bit          m_held  = 1'b0;      // a delivered word is frozen in the latch
    bit          m_drop  = 1'b0;      // the outstanding response belongs to a squashed path
`ifdef BTB_PREDICT_EN
    bit          m_bv   [256];
    logic [15:0] m_bpc  [256];
    logic [15:0] m_btgt [256];
    int          m_bcnt [256];
`endif

    function automatic logic [15:0] predict(input logic [15:0] a);
`ifdef BTB_PREDICT_EN
        if (m_bv[a[7:0]] && (m_bpc[a[7:0]] == a) && (m_bcnt[a[7:0]] >= 2))
            return m_btgt[a[7:0]];
`endif
        return a + 16'd1;
    endfunction

    function automatic bit model_valid();
        return !redirect && (m_held || (ifc.i_ready && !m_drop));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the clock edge, using the inputs the DUT sees at that edge.
    always @(posedge clk) begin
        if (reset) begin
            m_known <= 1'b1;
            m_addr  <= 16'h0000;
            m_next  <= 16'h0000;
            m_held  <= 1'b0;
            m_drop  <= 1'b0;
`ifdef BTB_PREDICT_EN
            for (int i = 0; i < 256; i++) begin
                m_bv[i]   <= 1'b0;
                m_bcnt[i] <= 1;
            end
`endif
        end else if (m_known) begin
`ifdef BTB_PREDICT_EN
            if (bp_update) begin
                if (m_bv[bp_update_pc[7:0]] && (m_bpc[bp_update_pc[7:0]] == bp_update_pc)) begin
                    if (bp_update_taken) begin
                        m_bcnt[bp_update_pc[7:0]] <= (m_bcnt[bp_update_pc[7:0]] >= 3) ? 3 : m_bcnt[bp_update_pc[7:0]] + 1;
                        m_btgt[bp_update_pc[7:0]] <= bp_update_target;
                    end else begin
                        m_bcnt[bp_update_pc[7:0]] <= (m_bcnt[bp_update_pc[7:0]] <= 0) ? 0 : m_bcnt[bp_update_pc[7:0]] - 1;
                    end
                end else if (bp_update_taken) begin
                    m_bv[bp_update_pc[7:0]]   <= 1'b1;
                    m_bpc[bp_update_pc[7:0]]  <= bp_update_pc;
                    m_btgt[bp_update_pc[7:0]] <= bp_update_target;
                    m_bcnt[bp_update_pc[7:0]] <= 2;
                end
            end
`endif
            if (redirect) begin
                m_next <= redirect_pc;
                if (!m_held && !ifc.i_ready) begin
                    m_drop <= 1'b1;
                end else begin
                    m_addr <= redirect_pc;
                    m_drop <= 1'b0;
                    m_held <= 1'b0;
                end
            end else if (m_held) begin
                if (!stall) begin
                    m_addr <= m_hpred;
                    m_next <= m_hpred;
                    m_held <= 1'b0;
                end
            end else if (m_drop) begin
                if (ifc.i_ready) begin
                    m_addr <= m_next;
                    m_drop <= 1'b0;
                end
            end else if (ifc.i_ready) begin
                if (stall) begin
                    m_held  <= 1'b1;
                    m_hword <= mem_word(m_addr);
                    m_hpred <= predict(m_addr);
                end else begin
                    m_addr <= predict(m_addr);
                    m_next <= predict(m_addr);
                end
            end
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (reset) begin
            chk("valid_in_reset", 16'(valid_IF), 16'h0000);
        end else if (m_known) begin
            chk("i_readM", 16'(ifc.i_readM), 16'(!m_held));
            if (!m_held) chk("i_address", ifc.i_address, m_addr);
            chk("valid_IF", 16'(valid_IF), 16'(model_valid()));
            if (model_valid()) begin
                chk("pc_IF", pc_IF, m_addr);
                chk("instruction_IF", instruction_IF, m_held ? m_hword : mem_word(m_addr));
                chk("pred_pc_IF", branch_predicted_pc_IF, m_held ? m_hpred : predict(m_addr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rst, input bit rdy, input bit st, input bit rd,
                        input logic [15:0] rpc, input bit bpu, input logic [15:0] bpc,
                        input logic [15:0] btgt, input bit btk);
        @(posedge clk);
        #1;
        reset            = rst;
        ifc.i_ready      = rdy;
        stall            = st;
        redirect         = rd;
        redirect_pc      = rpc;
        bp_update        = bpu;
        bp_update_pc     = bpc;
        bp_update_target = btgt;
        bp_update_taken  = btk;
        @(negedge clk);
    endtask

    task automatic cyc(input bit rdy, input bit st);
        step(1'b0, rdy, st, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic jump(input bit rdy, input logic [15:0] rpc);
        step(1'b0, rdy, 1'b0, 1'b1, rpc, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

`ifdef BTB_PREDICT_EN
    localparam logic [15:0] EXP_PRED5 = 16'h0040;
`else
    localparam logic [15:0] EXP_PRED5 = 16'h0006;
`endif

    initial begin
        ifc.i_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // Reset state
        cyc(1'b0, 1'b0);
        chk("rst_addr", ifc.i_address, 16'h0000);
        chk("rst_valid", 16'(valid_IF), 16'h0000);
        chk("rst_readM", 16'(ifc.i_readM), 16'h0001);

        // Single-cycle memory streams 0,1,2,3
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0);
            chk("seq_pc", pc_IF, 16'(k));
            chk("seq_valid", 16'(valid_IF), 16'h0001);
        end

        // Two taken trainings of 0x0005 -> 0x0040, then fetch 4, 5, target
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0040, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0040, 1'b1);
        cyc(1'b1, 1'b0);
        chk("bp_pc4", pc_IF, 16'h0004);
        cyc(1'b1, 1'b0);
        chk("bp_pc5", pc_IF, 16'h0005);
        chk("bp_pred5", branch_predicted_pc_IF, EXP_PRED5);
        cyc(1'b1, 1'b0);
        chk("bp_after5", pc_IF, EXP_PRED5);

        // Stall for 3 cycles on 0x0010
        jump(1'b1, 16'h0010);
        chk("redir_valid", 16'(valid_IF), 16'h0000);
        cyc(1'b1, 1'b1);
        chk("stall_pc", pc_IF, 16'h0010);
        chk("stall_instr", instruction_IF, 16'hFFEF);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1);
            chk("hold_readM", 16'(ifc.i_readM), 16'h0000);
            chk("hold_instr", instruction_IF, 16'hFFEF);
            chk("hold_valid", 16'(valid_IF), 16'h0001);
        end
        cyc(1'b1, 1'b0);
        chk("release_pc", pc_IF, 16'h0010);
        cyc(1'b1, 1'b0);
        chk("after_stall_pc", pc_IF, 16'h0011);

        // Redirect to 0x0100 during a 3-cycle read of 0x0020
        jump(1'b1, 16'h0020);
        cyc(1'b0, 1'b0);
        chk("pend_addr", ifc.i_address, 16'h0020);
        jump(1'b0, 16'h0100);
        chk("drain_valid0", 16'(valid_IF), 16'h0000);
        cyc(1'b0, 1'b0);
        chk("drain_addr", ifc.i_address, 16'h0020);
        cyc(1'b1, 1'b0);
        chk("drain_addr_rdy", ifc.i_address, 16'h0020);
        chk("drain_drop", 16'(valid_IF), 16'h0000);
        cyc(1'b1, 1'b0);
        chk("post_drain_addr", ifc.i_address, 16'h0100);
        chk("post_drain_valid", 16'(valid_IF), 16'h0001);

        // PC wrap at 0xFFFF
        jump(1'b1, 16'hFFFF);
        cyc(1'b1, 1'b0);
        chk("wrap_pc", pc_IF, 16'hFFFF);
        chk("wrap_pred", branch_predicted_pc_IF, 16'h0000);
        cyc(1'b1, 1'b0);
        chk("wrap_next", pc_IF, 16'h0000);

        // Reset during a pending read
        cyc(1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0);
        chk("rst2_addr", ifc.i_address, 16'h0000);
        chk("rst2_valid", 16'(valid_IF), 16'h0000);
        chk("rst2_readM", 16'(ifc.i_readM), 16'h0001);
        cyc(1'b1, 1'b0);
        chk("rst2_first_pc", pc_IF, 16'h0000);

        // Mixed traffic in a small address window so trained entries are hit
        for (int k = 0; k < 300; k++) begin
            step(1'b0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 11) == 0,
                 16'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1,
                 16'($urandom_range(0, 31)),
                 16'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0);
        end
        cyc(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
